// File: rtl/ternary_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ternary_pkg
//  Description : Shared balanced-ternary types and BTISA loader definitions.
//                trit_t is the 2-bit trit encoding used on every trit bus.
//                The package also holds the instruction field ranges, the
//                HALT opcode value, the program-loader state enum and the
//                loader error-code enum.
//  Revision    : 1.0  initial release
// ============================================================================
package ternary_pkg;

    // Balanced-ternary digit. All-zero bits decode as T_ZERO, so a cleared
    // register reads as a zero-valued word.
    typedef enum logic [1:0] {
        T_ZERO    = 2'b00,
        T_POS_ONE = 2'b01,
        T_NEG_ONE = 2'b10
    } trit_t;

    // HALT opcode: -11 = -9 - 3 + 1, trits (msb..lsb) - - +
    localparam int OP_HALT_VAL = -11;

    // Legal field ranges: 3 trits for op, 2 trits for rd/rs1/imm
    localparam int OP_TRITS  = 3;
    localparam int REG_TRITS = 2;
    localparam int OP_MIN    = -13;
    localparam int OP_MAX    = 13;
    localparam int REG_MIN   = -4;
    localparam int REG_MAX   = 4;
    localparam int IMM_MIN   = -4;
    localparam int IMM_MAX   = 4;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_LOAD  = 2'd1,
        LD_DONE  = 2'd2,
        LD_ERROR = 2'd3
    } ld_state_t;

    typedef enum logic [2:0] {
        ERR_NONE = 3'd0,
        ERR_OP   = 3'd1,
        ERR_REG  = 3'd2,
        ERR_IMM  = 3'd3,
        ERR_ADDR = 3'd4
    } ld_err_t;

endpackage
`default_nettype wire

// File: rtl/btisa_int2trits.sv
`default_nettype none
// ============================================================================
//  Module      : btisa_int2trits
//  Description : Combinational signed-integer to balanced-ternary converter.
//                Least-significant trit at index 0. in_range is high when the
//                value fits in NTRITS trits, i.e. |value| <= (3^NTRITS-1)/2.
//                trits is only meaningful when in_range is high.
//  Ports       : value    in  IN_W (signed)  integer to convert
//                trits    out trit_t[NTRITS-1:0]  balanced-ternary digits
//                in_range out 1              value representable
//  Revision    : 1.0  initial release
// ============================================================================
module btisa_int2trits
    import ternary_pkg::*;
#(
    parameter int NTRITS = 3,
    parameter int IN_W   = 5
) (
    input  logic signed [IN_W-1:0] value,
    output trit_t [NTRITS-1:0]     trits,
    output logic                   in_range
);

    localparam int c_max = (3 ** NTRITS - 1) / 2;

    // Digit rule: remainder 0 -> 0, remainder 1 -> +1, remainder 2 -> -1
    // (with a carry into the next position). SV '%' keeps the dividend's
    // sign, so negative remainders -1/-2 are folded onto the same cases.
    always_comb begin : p_convert
        int v;
        int r;
        trits    = '0;
        v        = int'(value);
        r        = 0;
        in_range = (v >= -c_max) && (v <= c_max);
        for (int i = 0; i < NTRITS; i++) begin
            r = v % 3;
            if (r == 0) begin
                trits[i] = T_ZERO;
            end else if ((r == 1) || (r == -2)) begin
                trits[i] = T_POS_ONE;
                v        = v - 1;
            end else begin
                trits[i] = T_NEG_ONE;
                v        = v + 1;
            end
            v = v / 3;
        end
    end

endmodule
`default_nettype wire

// File: rtl/btisa_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : btisa_program_loader
//  Description : Encodes binary instruction field bundles into 9-trit BTISA
//                words and writes them sequentially into instruction memory.
//                A session starts on 'start', runs until a HALT word is
//                written, or stops on a field range error / address overflow.
//  Ports       : clk, rst        clock, asynchronous active-high reset
//                start           begin session (ignored while loading)
//                in_valid/ready  field bundle handshake
//                in_op           signed opcode (-13..13)
//                in_rd/rs1/imm   signed register/immediate (-4..4)
//                mem_we/ready    write handshake, request held until ready
//                mem_addr/wdata  write address and encoded word
//                busy/done       session loading / finished at HALT
//                err_code        0 none, 1 op, 2 reg, 3 imm, 4 addr overflow
//                count           words written this session
//  Revision    : 1.0  initial release
// ============================================================================
module btisa_program_loader
    import ternary_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int PROG_BASE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rs1,
    input  logic [3:0]        in_imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output trit_t [8:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [2:0]        err_code,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] c_base      = ADDR_W'(PROG_BASE);
    localparam logic [ADDR_W-1:0] c_addr_last = '1;
    localparam logic [ADDR_W-1:0] c_addr_one  = 1;
    localparam logic [ADDR_W:0]   c_cnt_one   = 1;

    ld_state_t           r_state;
    ld_state_t           w_state_nxt;
    ld_err_t             r_err;
    ld_err_t             w_err_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_count;
    logic                r_mem_we;
    logic                r_halt_pend;
    trit_t [8:0]         r_wdata;

    trit_t [2:0]         w_op_t;
    trit_t [1:0]         w_rd_t;
    trit_t [1:0]         w_rs1_t;
    trit_t [1:0]         w_imm_t;
    logic                w_op_ok;
    logic                w_rd_ok;
    logic                w_rs1_ok;
    logic                w_imm_ok;
    logic                w_field_err;
    ld_err_t             w_field_code;
    logic                w_is_halt;
    logic                w_start;
    logic                w_write_acc;
    logic                w_bundle_acc;
    logic                w_last_addr;
    logic                w_terminal;

    // ------------------------------------------------------------------
    // Field converters
    // ------------------------------------------------------------------
    btisa_int2trits #(.NTRITS(OP_TRITS), .IN_W(5)) u_op (
        .value    (in_op),
        .trits    (w_op_t),
        .in_range (w_op_ok)
    );

    btisa_int2trits #(.NTRITS(REG_TRITS), .IN_W(4)) u_rd (
        .value    (in_rd),
        .trits    (w_rd_t),
        .in_range (w_rd_ok)
    );

    btisa_int2trits #(.NTRITS(REG_TRITS), .IN_W(4)) u_rs1 (
        .value    (in_rs1),
        .trits    (w_rs1_t),
        .in_range (w_rs1_ok)
    );

    btisa_int2trits #(.NTRITS(REG_TRITS), .IN_W(4)) u_imm (
        .value    (in_imm),
        .trits    (w_imm_t),
        .in_range (w_imm_ok)
    );

    // Error priority: op > reg (rd or rs1) > imm
    always_comb begin
        w_field_err  = 1'b1;
        w_field_code = ERR_NONE;
        if (!w_op_ok) begin
            w_field_code = ERR_OP;
        end else if (!w_rd_ok || !w_rs1_ok) begin
            w_field_code = ERR_REG;
        end else if (!w_imm_ok) begin
            w_field_code = ERR_IMM;
        end else begin
            w_field_err = 1'b0;
        end
    end

    assign w_is_halt   = (int'($signed(in_op)) == OP_HALT_VAL);
    assign w_start     = start && (r_state != LD_LOAD);
    assign w_write_acc = r_mem_we && mem_ready;
    assign w_last_addr = (r_addr == c_addr_last);

    // A pending HALT or a pending write at the top address ends the session,
    // so no further bundle may slip in behind it.
    assign w_terminal   = r_halt_pend || w_last_addr;
    assign in_ready     = (r_state == LD_LOAD) &&
                          (!r_mem_we || (mem_ready && !w_terminal));
    assign w_bundle_acc = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Session state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LD_IDLE;
            r_err   <= ERR_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        case (r_state)
            LD_LOAD: begin
                if (w_write_acc && r_halt_pend) begin
                    w_state_nxt = LD_DONE;
                end else if (w_write_acc && w_last_addr) begin
                    w_state_nxt = LD_ERROR;
                    w_err_nxt   = ERR_ADDR;
                end else if (w_bundle_acc && w_field_err) begin
                    w_state_nxt = LD_ERROR;
                    w_err_nxt   = w_field_code;
                end
            end
            default: begin
                if (start) begin
                    w_state_nxt = LD_LOAD;
                    w_err_nxt   = ERR_NONE;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // One-entry write register, address and word counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_count     <= '0;
            r_mem_we    <= 1'b0;
            r_halt_pend <= 1'b0;
            r_wdata     <= '0;
        end else if (w_start) begin
            r_addr      <= c_base;
            r_count     <= '0;
            r_halt_pend <= 1'b0;
        end else begin
            if (w_write_acc) begin
                r_count <= r_count + c_cnt_one;
                // Hold at the top address instead of wrapping
                if (!w_last_addr) begin
                    r_addr <= r_addr + c_addr_one;
                end
            end
            if (w_bundle_acc && !w_field_err) begin
                r_mem_we       <= 1'b1;
                r_halt_pend    <= w_is_halt;
                r_wdata[8:6]   <= w_op_t;
                r_wdata[5:4]   <= w_rd_t;
                r_wdata[3:2]   <= w_rs1_t;
                r_wdata[1:0]   <= w_imm_t;
            end else if (w_write_acc) begin
                r_mem_we <= 1'b0;
            end
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign busy      = (r_state == LD_LOAD);
    assign done      = (r_state == LD_DONE);
    assign err_code  = r_err;
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_btisa_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btisa_program_loader
//  Description : Self-checking bench for btisa_program_loader. Two instances:
//                dut_a with ADDR_W=8 for the main sessions and dut_b with
//                ADDR_W=2 for the address-overflow session. Expected words
//                come from a positional base-3 model of balanced ternary.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_btisa_program_loader;
    import ternary_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic        in_valid, mem_ready;
    logic [4:0]  in_op;
    logic [3:0]  in_rd, in_rs1, in_imm;

    logic        ready_a, we_a, busy_a, done_a;
    logic [7:0]  addr_a;
    trit_t [8:0] wdata_a;
    logic [2:0]  err_a;
    logic [8:0]  count_a;

    logic        ready_b, we_b, busy_b, done_b;
    logic [1:0]  addr_b;
    trit_t [8:0] wdata_b;
    logic [2:0]  err_b;
    logic [2:0]  count_b;

    logic [17:0] wa_bits, wb_bits;
    assign wa_bits = wdata_a;
    assign wb_bits = wdata_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          addr;
        logic [17:0] data;
        int          cyc;
    } wr_t;

    wr_t         obs_a[$];
    wr_t         obs_b[$];
    logic [17:0] exp_a[$];
    logic [17:0] exp_b[$];
    wr_t         mon_w;

    btisa_program_loader #(.ADDR_W(8), .PROG_BASE(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_ready(ready_a),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_imm(in_imm),
        .mem_we(we_a), .mem_ready(mem_ready), .mem_addr(addr_a), .mem_wdata(wdata_a),
        .busy(busy_a), .done(done_a), .err_code(err_a), .count(count_a)
    );

    btisa_program_loader #(.ADDR_W(2), .PROG_BASE(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_ready(ready_b),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_imm(in_imm),
        .mem_we(we_b), .mem_ready(mem_ready), .mem_addr(addr_b), .mem_wdata(wdata_b),
        .busy(busy_b), .done(done_b), .err_code(err_b), .count(count_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Record every accepted memory write mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (we_a && mem_ready) begin
                mon_w.addr = int'(addr_a);
                mon_w.data = wa_bits;
                mon_w.cyc  = cyc;
                obs_a.push_back(mon_w);
            end
            if (we_b && mem_ready) begin
                mon_w.addr = int'(addr_b);
                mon_w.data = wb_bits;
                mon_w.cyc  = cyc;
                obs_b.push_back(mon_w);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    // Shift v by (3^n-1)/2 into plain base-3 digits 0..2, then each trit is
    // digit-1.
    function automatic logic [5:0] tern(input int v, input int n);
        logic [5:0] res;
        int u;
        int d;
        res = '0;
        u   = v + ((n == 3) ? 13 : 4);
        for (int i = 0; i < n; i++) begin
            d = u % 3;
            u = u / 3;
            if (d == 0)      res[2*i +: 2] = T_NEG_ONE;
            else if (d == 1) res[2*i +: 2] = T_ZERO;
            else             res[2*i +: 2] = T_POS_ONE;
        end
        return res;
    endfunction

    function automatic logic [17:0] enc(input int op, input int rd, input int rs1, input int imm);
        logic [5:0] o, a, b, c;
        o = tern(op, 3);
        a = tern(rd, 2);
        b = tern(rs1, 2);
        c = tern(imm, 2);
        return {o, a[3:0], b[3:0], c[3:0]};
    endfunction

    function automatic int exp_err(input int op, input int rd, input int rs1, input int imm);
        if (op < OP_MIN || op > OP_MAX) return 1;
        if (rd < REG_MIN || rd > REG_MAX || rs1 < REG_MIN || rs1 > REG_MAX) return 2;
        if (imm < IMM_MIN || imm > IMM_MAX) return 3;
        return 0;
    endfunction

    function automatic int rnd_op_nohalt();
        int v;
        v = int'($urandom_range(0, 25)) - 13;
        if (v >= OP_HALT_VAL) v = v + 1;
        return v;
    endfunction

    function automatic int rnd_reg();
        return int'($urandom_range(0, 8)) - 4;
    endfunction

    function automatic int bad_op();
        int v;
        v = int'($urandom_range(0, 4));
        return (v < 3) ? (-16 + v) : (11 + v);
    endfunction

    function automatic int bad_reg();
        int v;
        v = int'($urandom_range(0, 6));
        return (v < 4) ? (-8 + v) : (1 + v);
    endfunction

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input bit sel_b);
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Present a bundle until accepted (bounded); returns at posedge+1 of the
    // accepting edge. Legal bundles are queued as expected writes.
    task automatic send(input bit sel_b, input int op, input int rd, input int rs1,
                        input int imm, input bit rnd);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_op    = op[4:0];
        in_rd    = rd[3:0];
        in_rs1   = rs1[3:0];
        in_imm   = imm[3:0];
        @(negedge clk);
        while (!(sel_b ? ready_b : ready_a) && n < 60) begin
            @(posedge clk); #1;
            if (rnd) mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        check("bundle_accept", 32'(sel_b ? ready_b : ready_a), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rnd) mem_ready = 1'($urandom_range(0, 1));
        if (exp_err(op, rd, rs1, imm) == 0) begin
            if (sel_b) exp_b.push_back(enc(op, rd, rs1, imm));
            else       exp_a.push_back(enc(op, rd, rs1, imm));
        end
    endtask

    task automatic wait_done();
        int n;
        n         = 0;
        mem_ready = 1'b1;
        @(negedge clk);
        while (!done_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", 32'(done_a), 32'd1);
    endtask

    task automatic compare_writes(input bit sel_b);
        int  n_obs;
        int  n_exp;
        wr_t w;
        n_obs = sel_b ? obs_b.size() : obs_a.size();
        n_exp = sel_b ? exp_b.size() : exp_a.size();
        check("write_count", 32'(n_obs), 32'(n_exp));
        for (int i = 0; i < n_obs && i < n_exp; i++) begin
            if (sel_b) w = obs_b[i]; else w = obs_a[i];
            check("write_addr", 32'(w.addr), 32'(i));
            check("write_data", 32'(w.data), 32'(sel_b ? exp_b[i] : exp_a[i]));
        end
    endtask

    task automatic clear_queues();
        obs_a.delete(); obs_b.delete();
        exp_a.delete(); exp_b.delete();
    endtask

    // ------------------------------------------------------------------
    // Directed/random sequence
    // ------------------------------------------------------------------
    initial begin
        int op, rd, rs1, imm, k, words;
        rst       = 1'b1;
        start_a   = 1'b0;
        start_b   = 1'b0;
        in_valid  = 1'b0;
        mem_ready = 1'b1;
        in_op     = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_imm    = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(ready_a), 32'd0);
        check("rst_mem_we",   32'(we_a),    32'd0);
        check("rst_addr",     32'(addr_a),  32'd0);
        check("rst_wdata",    32'(wa_bits), 32'd0);
        check("rst_busy",     32'(busy_a),  32'd0);
        check("rst_done",     32'(done_a),  32'd0);
        check("rst_err",      32'(err_a),   32'd0);
        check("rst_count",    32'(count_a), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single directed word: op=0 rd=1 rs1=2 imm=3 -> 000 0+ +- +0
        clear_queues();
        pulse_start(1'b0);
        @(negedge clk);
        check("start_busy",  32'(busy_a),  32'd1);
        check("start_ready", 32'(ready_a), 32'd1);
        @(posedge clk); #1;
        send(1'b0, 0, 1, 2, 3, 1'b0);
        @(negedge clk);
        check("first_we",    32'(we_a),    32'd1);
        check("first_addr",  32'(addr_a),  32'd0);
        check("first_word",  32'(wa_bits), 32'({6'b000000, 4'b0001, 4'b0110, 4'b0100}));
        @(posedge clk); #1;
        send(1'b0, OP_HALT_VAL, rnd_reg(), rnd_reg(), rnd_reg(), 1'b0);
        wait_done();
        compare_writes(1'b0);

        // Four back-to-back bundles ending in HALT, memory always ready
        clear_queues();
        pulse_start(1'b0);
        for (int i = 0; i < 3; i++) send(1'b0, rnd_op_nohalt(), rnd_reg(), rnd_reg(), rnd_reg(), 1'b0);
        send(1'b0, OP_HALT_VAL, rnd_reg(), rnd_reg(), rnd_reg(), 1'b0);
        wait_done();
        compare_writes(1'b0);
        if (obs_a.size() >= 4) begin
            for (int i = 1; i < 4; i++) check("consecutive", 32'(obs_a[i].cyc - obs_a[0].cyc), 32'(i));
            check("halt_trits", 32'(obs_a[3].data[17:12]), 32'(6'b101001));
        end
        check("stream_count", 32'(count_a), 32'd4);
        check("stream_busy",  32'(busy_a),  32'd0);
        check("stream_ready", 32'(ready_a), 32'd0);

        // Back-pressure: 3 stalled cycles, then random mem_ready
        clear_queues();
        pulse_start(1'b0);
        mem_ready = 1'b0;
        op = rnd_op_nohalt(); rd = rnd_reg(); rs1 = rnd_reg(); imm = rnd_reg();
        send(1'b0, op, rd, rs1, imm, 1'b0);
        op = rnd_op_nohalt(); rd = rnd_reg(); rs1 = rnd_reg(); imm = rnd_reg();
        in_valid = 1'b1;
        in_op = op[4:0]; in_rd = rd[3:0]; in_rs1 = rs1[3:0]; in_imm = imm[3:0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_we",    32'(we_a),    32'd1);
            check("stall_addr",  32'(addr_a),  32'd0);
            check("stall_data",  32'(wa_bits), 32'(exp_a[0]));
            check("stall_ready", 32'(ready_a), 32'd0);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        send(1'b0, op, rd, rs1, imm, 1'b0);
        for (int i = 0; i < 6; i++) send(1'b0, rnd_op_nohalt(), rnd_reg(), rnd_reg(), rnd_reg(), 1'b1);
        send(1'b0, OP_HALT_VAL, rnd_reg(), rnd_reg(), rnd_reg(), 1'b1);
        wait_done();
        compare_writes(1'b0);
        check("bp_count", 32'(count_a), 32'd9);

        // Range error on rd, no write issued
        clear_queues();
        mem_ready = 1'b1;
        pulse_start(1'b0);
        send(1'b0, rnd_op_nohalt(), 5, rnd_reg(), rnd_reg(), 1'b0);
        @(negedge clk);
        check("rd_err_code",  32'(err_a),   32'd2);
        check("rd_err_busy",  32'(busy_a),  32'd0);
        check("rd_err_we",    32'(we_a),    32'd0);
        check("rd_err_count", 32'(count_a), 32'd0);
        check("rd_err_nowr",  32'(obs_a.size()), 32'd0);

        // Random error bundles behind a legal pending write
        for (int t = 0; t < 8; t++) begin
            clear_queues();
            pulse_start(1'b0);
            @(negedge clk);
            check("restart_err",   32'(err_a),   32'd0);
            check("restart_count", 32'(count_a), 32'd0);
            @(posedge clk); #1;
            send(1'b0, rnd_op_nohalt(), rnd_reg(), rnd_reg(), rnd_reg(), 1'b0);
            op  = ($urandom_range(0, 3) == 0) ? bad_op()  : rnd_op_nohalt();
            rd  = ($urandom_range(0, 3) == 0) ? bad_reg() : rnd_reg();
            rs1 = ($urandom_range(0, 3) == 0) ? bad_reg() : rnd_reg();
            imm = ($urandom_range(0, 3) == 0) ? bad_reg() : rnd_reg();
            k   = int'($urandom_range(0, 3));
            if (k == 0) op = bad_op();
            else if (k == 1) rd = bad_reg();
            else if (k == 2) rs1 = bad_reg();
            else imm = bad_reg();
            send(1'b0, op, rd, rs1, imm, 1'b0);
            @(negedge clk);
            check("rand_err_code",  32'(err_a),   32'(exp_err(op, rd, rs1, imm)));
            check("rand_err_count", 32'(count_a), 32'd1);
            check("rand_err_we",    32'(we_a),    32'd0);
            compare_writes(1'b0);
            @(posedge clk); #1;
        end

        // Address overflow on the 4-word instance
        clear_queues();
        pulse_start(1'b1);
        for (int i = 0; i < 4; i++) send(1'b1, rnd_op_nohalt(), rnd_reg(), rnd_reg(), rnd_reg(), 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ovf_no_accept", 32'(ready_b), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("ovf_err",   32'(err_b),   32'd4);
        check("ovf_count", 32'(count_b), 32'd4);
        check("ovf_busy",  32'(busy_b),  32'd0);
        check("ovf_done",  32'(done_b),  32'd0);
        check("ovf_we",    32'(we_b),    32'd0);
        compare_writes(1'b1);
        @(posedge clk); #1;

        // Reset during a pending write
        clear_queues();
        pulse_start(1'b0);
        mem_ready = 1'b0;
        send(1'b0, rnd_op_nohalt(), rnd_reg(), rnd_reg(), rnd_reg(), 1'b0);
        @(negedge clk);
        check("pre_rst_we", 32'(we_a), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_we",    32'(we_a),    32'd0);
        check("arst_ready", 32'(ready_a), 32'd0);
        check("arst_busy",  32'(busy_a),  32'd0);
        check("arst_count", 32'(count_a), 32'd0);
        check("arst_addr",  32'(addr_a),  32'd0);
        check("arst_wdata", 32'(wa_bits), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst       = 1'b0;
        mem_ready = 1'b1;
        clear_queues();
        pulse_start(1'b0);
        op = rnd_op_nohalt(); rd = rnd_reg(); rs1 = rnd_reg(); imm = rnd_reg();
        send(1'b0, op, rd, rs1, imm, 1'b0);
        @(negedge clk);
        check("resume_we",   32'(we_a),    32'd1);
        check("resume_addr", 32'(addr_a),  32'd0);
        check("resume_data", 32'(wa_bits), 32'(enc(op, rd, rs1, imm)));
        @(posedge clk); #1;
        send(1'b0, OP_HALT_VAL, rnd_reg(), rnd_reg(), rnd_reg(), 1'b0);
        wait_done();
        compare_writes(1'b0);
        words = obs_a.size();
        check("resume_count", 32'(count_a), 32'(words));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/btisa_program_loader.md
# btisa_program_loader

Encodes a stream of binary-integer instruction fields into 9-trit BTISA instruction words and writes them sequentially into instruction memory. It is the encoder counterpart of the BTISA decoder: it produces the words the decoder consumes. It sits between the host/debug bootstrap interface and the instruction-memory write port, and runs a load session that ends at a HALT instruction or on an error.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory address width; depth is 2^ADDR_W.
- PROG_BASE, 0, first write address of a session.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begins a load session; sampled only in IDLE, DONE or ERROR.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  field bundle accepted when in_valid && in_ready.
- in_op  in  5 (signed)  opcode value; legal range -13..+13.
- in_rd, in_rs1  in  4 (signed)  register indices; legal range -4..+4.
- in_imm  in  4 (signed)  rs2/immediate; legal range -4..+4.
- mem_we  out  1  write request; held until mem_ready.
- mem_ready  in  1  memory accepts the write when mem_we && mem_ready.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  trit_t[8:0]  encoded word: [8:6] op, [5:4] rd, [3:2] rs1, [1:0] imm.
- busy  out  1  state == LOAD.
- done  out  1  state == DONE.
- err_code  out  3  0 none, 1 op range, 2 reg range, 3 imm range, 4 address overflow.
- count  out  ADDR_W+1  words written this session.

## Operation
- Each field is converted from an integer to balanced ternary, least-significant trit at the lowest index. Value = Σ t_i·3^i, with t_i ∈ {T_NEG_ONE, T_ZERO, T_POS_ONE}.
- State machine: IDLE, LOAD, DONE, ERROR.
  - IDLE/DONE/ERROR -> LOAD on start. This sets addr=PROG_BASE, count=0 and err_code=0.
  - LOAD -> DONE after the write of a word whose opcode is HALT (value -11, trits --+) is accepted by the memory.
  - LOAD -> ERROR when an accepted bundle has any field out of range. That bundle is not written. The error code uses priority op > reg > imm.
  - LOAD -> ERROR with code 4 when a non-HALT word is written at address 2^ADDR_W-1. That word is written; no address wrap occurs.
- One-entry write register: in_ready = (state == LOAD) && (!mem_we || mem_ready). This gives throughput of 1 word/cycle when mem_ready is held high.
- mem_addr and mem_wdata are stable while mem_we is high. After each accepted write, addr and count increment.
- All 27 opcode values are assigned, so no opcode is illegal within -13..+13.
- start while in LOAD is ignored.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata all T_ZERO, busy=0, done=0, err_code=0, count=0, state=IDLE.
- start at cycle N: busy=1 and in_ready=1 at N+1.
- Bundle accepted at cycle N: mem_we=1 with the encoded word at N+1. Latency is 1 cycle.
- Write accepted at cycle M with no new bundle: mem_we=0 at M+1.
- HALT write accepted at M: done=1 and busy=0 at M+1. No further bundles are accepted.
- Range error on the bundle accepted at N: err_code is valid and the state is ERROR at N+1. Any earlier pending write still completes; mem_we stays high until mem_ready.
- Reset asserted mid-write: mem_we drops immediately (asynchronous). The partially loaded program is abandoned.

## Structure
- ternary_pkg gains:
  - localparam OP_HALT_VAL = -11;
  - range constants for the op and reg/imm fields;
  - an enum for the loader state;
  - an enum for err_code.
- Sub-module btisa_int2trits, parameterised by NTRITS (2 or 3). It is a combinational signed-integer-to-trit_t[NTRITS-1:0] converter using the standard balanced-ternary digit rule, with a range flag output. It is instantiated 4×.

## Test plan
- start; op=0, rd=1, rs1=2, imm=3 -> mem_wdata = op 000, rd 0+, rs1 +-, imm +0 at PROG_BASE, one cycle after acceptance.
- Stream 4 bundles, last with op=-11, with mem_ready=1 -> 4 writes on consecutive cycles at addresses 0..3, op trits of the last word --+, done=1, count=4.
- mem_ready low for 3 cycles -> mem_we, addr and data held stable; in_ready=0; no bundle lost.
- in_rd=5 -> err_code=2, no write, state ERROR. A new start clears err_code and count.
- ADDR_W=2, five non-HALT bundles -> 4 writes (addresses 0..3), err_code=4, fifth bundle not accepted.
- Assert rst while mem_we=1 -> all outputs at reset values in the same cycle; start afterwards resumes at PROG_BASE.
